updown_generic_counter: RTL and testbench
=========================================

Name: updown_generic_counter

Overview:
Parametrised successor to the team's simple wrap counter, used for game-tick timing, grid-coordinate stepping and score digits. Adds up/down direction, a runtime terminal value, synchronous load, and wrap or saturate mode. Provides a registered terminal-count pulse for cascading, plus a combinational at-terminal flag. Instances sit directly on the system clock and chain via TRIG_OUT -> ENABLE.

Parameters:
COUNTER_WIDTH, 8, width of COUNT, LOAD_VALUE and MAX_VALUE
PRESCALE_WIDTH, 4, width of PRESCALE port and internal prescale counter (used only with macro)

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
ENABLE  input  1  step request; a step occurs on a rising edge with ENABLE=1 (and prescale tick, if compiled in)
LOAD  input  1  synchronous load strobe
LOAD_VALUE  input  COUNTER_WIDTH  value written on LOAD
MAX_VALUE  input  COUNTER_WIDTH  runtime upper bound; sampled every cycle
DIR  input  1  1 = count up, 0 = count down
SATURATE  input  1  1 = hold at terminal, 0 = wrap
PRESCALE  input  PRESCALE_WIDTH  divide ratio minus one (ignored without macro)
COUNT  output  COUNTER_WIDTH  current count, registered
TRIG_OUT  output  1  registered one-cycle pulse after a step taken at terminal
TERMINAL  output  1  combinational: COUNT is at the terminal value for the current DIR

Behaviour:
- Reset is async, active-high. While RESET=1: COUNT=0, TRIG_OUT=0, prescale counter=0. TERMINAL follows COUNT (1 if DIR=0).
- Terminal value: DIR=1 -> COUNT>=MAX_VALUE; DIR=0 -> COUNT==0.
- Priority per edge: RESET > LOAD > step > hold.
- LOAD: COUNT <= min(LOAD_VALUE, MAX_VALUE).
  - TRIG_OUT <= 0.
  - Prescale counter cleared.
  - ENABLE ignored that cycle.
- Step, DIR=1:
  - COUNT<MAX_VALUE -> COUNT+1.
  - COUNT>=MAX_VALUE -> 0 (wrap) or MAX_VALUE (saturate).
- Step, DIR=0:
  - COUNT>MAX_VALUE -> MAX_VALUE, no trigger.
  - 0<COUNT<=MAX_VALUE -> COUNT-1.
  - COUNT==0 -> MAX_VALUE (wrap) or 0 (saturate).
- TRIG_OUT <= 1 exactly on edges where a step is taken while TERMINAL=1, otherwise 0.
  - Latency: one cycle after the terminal step, matching the legacy counter.
  - In saturate mode it pulses on every step taken while held at terminal.
- No step: COUNT holds and TRIG_OUT <= 0.
- MAX_VALUE=0: up/wrap stays at 0 and pulses TRIG_OUT on every step; down behaves the same.
- DIR, SATURATE and MAX_VALUE changes take effect on the next edge; there are no pipeline stages.
- All arithmetic is modulo 2^COUNTER_WIDTH, but the terminal checks keep the count within range. With MAX_VALUE=all-ones, wrap up from all-ones goes to 0.
- Reset asserted mid-count clears state immediately. The first step after release starts from 0.

Optional Feature:
Macro UPDOWN_COUNTER_PRESCALE_EN.
- Defined:
  - An internal PRESCALE_WIDTH counter advances on each ENABLE=1 edge.
  - A step is taken only on the ENABLE edge where the prescale counter == PRESCALE; that edge also resets it to 0.
  - PRESCALE=0 steps on every ENABLE.
  - A PRESCALE change takes effect at the next comparison. If the prescale counter is already > PRESCALE, the next ENABLE edge steps and clears it.
  - The prescale counter is cleared by RESET and LOAD, and holds while ENABLE=0.
- Undefined: no prescale register; every ENABLE edge is a step; the PRESCALE port is unused.

Test Plan:
- Up/wrap count: MAX_VALUE=9, DIR=1, SATURATE=0, ENABLE=1 for 12 cycles -> COUNT 1..9,0,1,2. TRIG_OUT high only in the cycle after the 9->0 edge.
- Down/saturate: LOAD_VALUE=3, MAX_VALUE=9, LOAD pulse, then DIR=0, SATURATE=1, 5 steps -> COUNT 2,1,0,0,0. TRIG_OUT pulses after the 4th and 5th steps; TERMINAL=1 from the third step on.
- Load clamp and priority: MAX_VALUE=5, LOAD_VALUE=200, LOAD=1 with ENABLE=1 -> COUNT=5, TRIG_OUT=0. Next up step -> COUNT=0, TRIG_OUT=1.
- Runtime MAX shrink: COUNT=8, MAX_VALUE changed to 4. DIR=1 step -> 0 with a TRIG pulse. Repeat with DIR=0 -> COUNT=4, no TRIG.
- Async reset: assert RESET mid-cycle at COUNT=6 -> COUNT=0 and TRIG_OUT=0 before the next CLK edge. After release, first step gives COUNT=1.
- Prescale (macro on): PRESCALE=2, MAX_VALUE=9, DIR=1, ENABLE=1 for 9 cycles -> COUNT increments on the 3rd, 6th and 9th edges only (1,2,3). LOAD mid-sequence restarts the 3-edge spacing.

Source files
------------

// File: rtl/updown_generic_counter_if.sv
// Bus bundle for updown_generic_counter: control inputs, runtime bounds and count outputs.
// PRESCALE is only consumed when UPDOWN_COUNTER_PRESCALE_EN is defined.
interface updown_generic_counter_if #(
  parameter int unsigned COUNTER_WIDTH  = 8,
  parameter int unsigned PRESCALE_WIDTH = 4
);
  logic                      ENABLE;
  logic                      LOAD;
  logic [COUNTER_WIDTH-1:0]  LOAD_VALUE;
  logic [COUNTER_WIDTH-1:0]  MAX_VALUE;
  logic                      DIR;
  logic                      SATURATE;
  logic [PRESCALE_WIDTH-1:0] PRESCALE;
  logic [COUNTER_WIDTH-1:0]  COUNT;
  logic                      TRIG_OUT;
  logic                      TERMINAL;

  modport master (
    output ENABLE, LOAD, LOAD_VALUE, MAX_VALUE, DIR, SATURATE, PRESCALE,
    input  COUNT, TRIG_OUT, TERMINAL
  );

  modport slave (
    input  ENABLE, LOAD, LOAD_VALUE, MAX_VALUE, DIR, SATURATE, PRESCALE,
    output COUNT, TRIG_OUT, TERMINAL
  );
endinterface

// File: rtl/updown_generic_counter.sv
// Up/down counter with runtime terminal value, load clamp, wrap/saturate and cascade pulse.
// Optional enable prescaler compiled in with UPDOWN_COUNTER_PRESCALE_EN.
module updown_generic_counter #(
  parameter int unsigned COUNTER_WIDTH  = 8,
  parameter int unsigned PRESCALE_WIDTH = 4
) (
  input logic                    CLK,
  input logic                    RESET,
  updown_generic_counter_if.slave bus
);
  localparam int unsigned CW = COUNTER_WIDTH;
  localparam int unsigned PW = PRESCALE_WIDTH;

  logic [CW-1:0] count_q, count_d;
  logic          trig_q, trig_d;
  logic          terminal_c;
  logic          step_c;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  logic [PW-1:0] pre_q, pre_d;
  logic          pre_tick_c;

  // >= so a PRESCALE lowered below the running count fires on the next enable
  assign pre_tick_c = (pre_q >= bus.PRESCALE);
  assign step_c     = bus.ENABLE & pre_tick_c;

  always_comb begin
    pre_d = pre_q;
    if (bus.LOAD) begin
      pre_d = '0;
    end else if (bus.ENABLE) begin
      pre_d = pre_tick_c ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^bus.PRESCALE;
  assign step_c          = bus.ENABLE;
`endif

  assign terminal_c = bus.DIR ? (count_q >= bus.MAX_VALUE) : (count_q == '0);

  // Next count / trigger: load beats step beats hold
  always_comb begin
    count_d = count_q;
    trig_d  = 1'b0;
    if (bus.LOAD) begin
      count_d = (bus.LOAD_VALUE > bus.MAX_VALUE) ? bus.MAX_VALUE : bus.LOAD_VALUE;
    end else if (step_c) begin
      trig_d = terminal_c;
      if (bus.DIR) begin
        if (count_q < bus.MAX_VALUE) begin
          count_d = count_q + CW'(1);
        end else begin
          count_d = bus.SATURATE ? bus.MAX_VALUE : '0;
        end
      end else begin
        if (count_q > bus.MAX_VALUE) begin
          count_d = bus.MAX_VALUE;
        end else if (count_q == '0) begin
          count_d = bus.SATURATE ? '0 : bus.MAX_VALUE;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
      trig_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      trig_q  <= trig_d;
    end
  end

  assign bus.COUNT    = count_q;
  assign bus.TRIG_OUT = trig_q;
  assign bus.TERMINAL = terminal_c;
endmodule

// File: tb/tb_updown_generic_counter.sv
// Directed self-checking bench for updown_generic_counter; prescale steps run only
// when UPDOWN_COUNTER_PRESCALE_EN is defined.
module tb_updown_generic_counter;
  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  updown_generic_counter_if #(.COUNTER_WIDTH(8), .PRESCALE_WIDTH(4)) bus ();

  updown_generic_counter #(.COUNTER_WIDTH(8), .PRESCALE_WIDTH(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [7:0] val);
    bus.LOAD       = 1'b1;
    bus.LOAD_VALUE = val;
    tick();
    bus.LOAD       = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_cnt [12];
    logic [7:0] exp_pre [9];
    checks = 0;
    errors = 0;
    exp_cnt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd1, 8'd2};
    exp_pre = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3};

    RESET          = 1'b1;
    bus.ENABLE     = 1'b0;
    bus.LOAD       = 1'b0;
    bus.LOAD_VALUE = '0;
    bus.MAX_VALUE  = 8'd9;
    bus.DIR        = 1'b0;
    bus.SATURATE   = 1'b0;
    bus.PRESCALE   = '0;
    #1;
    check("reset_count", 32'(bus.COUNT), 0);
    check("reset_trig", 32'(bus.TRIG_OUT), 0);
    check("reset_terminal_down", 32'(bus.TERMINAL), 1);
    tick();
    tick();
    RESET = 1'b0;

    // Up / wrap over MAX_VALUE=9
    bus.DIR    = 1'b1;
    bus.ENABLE = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("upwrap_count[%0d]", i), 32'(bus.COUNT), 32'(exp_cnt[i]));
      check($sformatf("upwrap_trig[%0d]", i), 32'(bus.TRIG_OUT), (i == 9) ? 1 : 0);
      if (i == 8) check("upwrap_terminal_at_9", 32'(bus.TERMINAL), 1);
    end
    bus.ENABLE = 1'b0;

    // Down / saturate from 3
    do_load(8'd3);
    check("dsat_load", 32'(bus.COUNT), 3);
    bus.DIR      = 1'b0;
    bus.SATURATE = 1'b1;
    bus.ENABLE   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("dsat_count[%0d]", i), 32'(bus.COUNT), (i < 2) ? 32'(2 - i) : 0);
      check($sformatf("dsat_trig[%0d]", i), 32'(bus.TRIG_OUT), (i >= 3) ? 1 : 0);
      check($sformatf("dsat_terminal[%0d]", i), 32'(bus.TERMINAL), (i >= 2) ? 1 : 0);
    end

    // Load clamp, load beats enable, trigger cleared by load
    bus.MAX_VALUE = 8'd5;
    do_load(8'd200);
    check("clamp_count", 32'(bus.COUNT), 5);
    check("clamp_trig", 32'(bus.TRIG_OUT), 0);
    bus.DIR      = 1'b1;
    bus.SATURATE = 1'b0;
    tick();
    check("clamp_wrap_count", 32'(bus.COUNT), 0);
    check("clamp_wrap_trig", 32'(bus.TRIG_OUT), 1);

    // Runtime MAX shrink, up then down
    bus.ENABLE    = 1'b0;
    bus.MAX_VALUE = 8'd9;
    do_load(8'd8);
    bus.MAX_VALUE = 8'd4;
    #1;
    check("shrink_terminal_up", 32'(bus.TERMINAL), 1);
    bus.ENABLE = 1'b1;
    tick();
    check("shrink_up_count", 32'(bus.COUNT), 0);
    check("shrink_up_trig", 32'(bus.TRIG_OUT), 1);
    bus.ENABLE    = 1'b0;
    bus.MAX_VALUE = 8'd9;
    do_load(8'd8);
    bus.MAX_VALUE = 8'd4;
    bus.DIR       = 1'b0;
    #1;
    check("shrink_terminal_down", 32'(bus.TERMINAL), 0);
    bus.ENABLE = 1'b1;
    tick();
    check("shrink_down_count", 32'(bus.COUNT), 4);
    check("shrink_down_trig", 32'(bus.TRIG_OUT), 0);

    // MAX_VALUE=0: every step is terminal
    bus.ENABLE    = 1'b0;
    bus.MAX_VALUE = 8'd0;
    do_load(8'd0);
    bus.DIR    = 1'b1;
    bus.ENABLE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("max0_count[%0d]", i), 32'(bus.COUNT), 0);
      check($sformatf("max0_trig[%0d]", i), 32'(bus.TRIG_OUT), 1);
    end

    // All-ones bound wraps to 0
    bus.ENABLE    = 1'b0;
    bus.MAX_VALUE = 8'hFF;
    do_load(8'hFF);
    check("ones_load", 32'(bus.COUNT), 255);
    bus.ENABLE = 1'b1;
    tick();
    check("ones_wrap_count", 32'(bus.COUNT), 0);
    check("ones_wrap_trig", 32'(bus.TRIG_OUT), 1);

    // Async reset mid-cycle
    bus.ENABLE    = 1'b0;
    bus.MAX_VALUE = 8'd9;
    do_load(8'd6);
    check("areset_pre", 32'(bus.COUNT), 6);
    #2;
    RESET = 1'b1;
    #1;
    check("areset_count", 32'(bus.COUNT), 0);
    check("areset_trig", 32'(bus.TRIG_OUT), 0);
    #2;
    RESET      = 1'b0;
    bus.DIR    = 1'b1;
    bus.ENABLE = 1'b1;
    tick();
    check("areset_first_step", 32'(bus.COUNT), 1);

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    // Prescale by 3, then load restarts spacing
    bus.ENABLE   = 1'b0;
    bus.PRESCALE = 4'd2;
    do_load(8'd0);
    bus.ENABLE = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("pre_count[%0d]", i), 32'(bus.COUNT), 32'(exp_pre[i]));
    end
    tick();
    tick();
    check("pre_hold", 32'(bus.COUNT), 3);
    do_load(8'd0);
    check("pre_load", 32'(bus.COUNT), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("pre_restart[%0d]", i), 32'(bus.COUNT), (i == 2) ? 1 : 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
